instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the instruction stream consumed by `instruction_decode`.
- Holds the PC and issues one word request at a time to instruction memory over a valid/ready request channel with a valid-only response channel.
- Delivers `{instr, pc}` pairs to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards stale responses.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset (bits [1:0] must be 0).
- NOP_INSTR, 32'h00000013, value driven on instr_o when no valid instruction (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  synchronous active-low reset
- imem_req_valid_o  output  1  fetch request valid
- imem_req_ready_i  input  1  memory accepts request
- imem_addr_o  output  32  byte address of request, always word-aligned
- imem_rsp_valid_i  input  1  response data valid; exactly one per accepted request, at least 1 cycle after acceptance
- imem_rsp_data_i  input  `INSTR_WIDTH  fetched instruction word
- instr_valid_o  output  1  instr_o/pc_o valid toward decode
- instr_ready_i  input  1  decode accepts instruction
- instr_o  output  `INSTR_WIDTH  instruction to decode
- pc_o  output  32  address of instr_o
- redirect_i  input  1  redirect request from execute (single-cycle pulse or level)
- redirect_pc_i  input  32  target PC; bits [1:0] ignored (forced 0)
- fetch_count_o  output  32  number of instructions accepted by decode

Behaviour:
- Reset (rstn=0 at clk edge), regardless of state:
  - pc_q=RESET_PC, state=REQ.
  - instr_valid_o=0, instr_o=NOP_INSTR, pc_o=RESET_PC, fetch_count_o=0.
  - A pending memory response is NOT tracked after reset; the memory is reset in the same cycle.
- imem_req_valid_o=1 only in REQ. imem_addr_o=pc_q (combinational from the register). Both are 0 while rstn=0.
- States:
  - REQ:
    - req handshake, no redirect -> WAIT.
    - redirect without handshake -> pc_q<=redirect_pc_i&~3, stay REQ.
    - redirect with handshake -> pc_q<=target, go FLUSH (request in flight carries the old address).
  - WAIT:
    - rsp_valid, no redirect -> instr_o<=rsp_data, pc_o<=pc_q, instr_valid_o<=1, pc_q<=pc_q+4, go HOLD.
    - redirect with rsp_valid -> response dropped, pc_q<=target, go REQ.
    - redirect without rsp_valid -> pc_q<=target, go FLUSH.
  - FLUSH:
    - rsp_valid -> drop data, go REQ.
    - redirect -> update pc_q, stay (or go REQ if rsp_valid the same cycle).
  - HOLD:
    - instr_valid_o=1; instr_o and pc_o stable until the handshake.
    - instr_valid_o & instr_ready_i -> fetch_count_o+1, instr_valid_o<=0, instr_o<=NOP_INSTR, go REQ.
    - redirect -> instr_valid_o<=0, pc_q<=target, go REQ. A handshake in the same cycle still counts (decode consumed it).
- Priority: reset > redirect > normal PC increment.
- Arithmetic:
  - pc_q+4 is modulo 2^32 (32'hFFFFFFFC -> 32'h0).
  - fetch_count_o wraps at 2^32.
- Latency with zero-wait memory (ready=1, response 1 cycle after acceptance):
  - REQ at cycle n, rsp at n+1, instr_valid_o at n+2.
  - With instr_ready_i=1, next REQ at n+3, i.e. one instruction per 3 cycles.
- Only one request outstanding, ever. A response arriving in REQ or HOLD is a protocol violation; assertion-flag it in simulation only.

Test Plan:
- Reset hold 3 cycles, release; memory returns 0x00500093, 0x00A00113 with 1-cycle latency, decode ready=1 -> imem_addr_o=0x0 then 0x4; decode sees (pc 0x0, 0x00500093), (pc 0x4, 0x00A00113); fetch_count_o=2; no imem request during reset.
- imem_req_ready_i low 4 cycles -> req_valid and addr 0x0 stay stable, no WAIT entry; accepted on cycle 5.
- instr_ready_i low 5 cycles in HOLD -> instr_o/pc_o unchanged, no new imem request, fetch_count_o unchanged; raise ready -> count+1, next addr = pc+4.
- Redirect to 0x103 during WAIT (response 3 cycles later) -> FLUSH, stale data never reaches decode, next request addr=0x100; redirect coincident with rsp_valid -> data dropped, next addr=0x100 directly.
- RESET_PC=32'hFFFFFFFC -> first fetch at 0xFFFFFFFC, second at 0x0; rstn low while in WAIT -> outputs return to reset values next edge, fetch restarts at RESET_PC.
- Redirect coincident with decode handshake in HOLD -> fetch_count_o increments, next addr=redirect target.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one imem word request at a time,
// and hands {instr, pc} to decode; redirects from execute discard stale responses.
module instr_fetch_unit #(
   parameter int unsigned            INSTR_WIDTH = 32,
   parameter logic [31:0]            RESET_PC    = 32'h0000_0000,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
   input  logic                   clk,
   input  logic                   rstn,
   output logic                   imem_req_valid_o,
   input  logic                   imem_req_ready_i,
   output logic [31:0]            imem_addr_o,
   input  logic                   imem_rsp_valid_i,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
   output logic                   instr_valid_o,
   input  logic                   instr_ready_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [31:0]            pc_o,
   input  logic                   redirect_i,
   input  logic [31:0]            redirect_pc_i,
   output logic [31:0]            fetch_count_o
);

   localparam int unsigned PC_W = 32;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH, S_HOLD} state_e;

   state_e                 state_q, state_d;
   logic [PC_W-1:0]        pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [PC_W-1:0]        pc_out_q, pc_out_d;
   logic                   valid_q, valid_d;
   logic [31:0]            count_q, count_d;
   logic [PC_W-1:0]        target;

   assign target = redirect_pc_i & ~PC_W'(3);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pc_out_q <= RESET_PC;
         valid_q  <= 1'b0;
         count_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
      end
   end

   // Next-state logic; redirect outranks the sequential PC advance
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      count_d  = count_q;
      case (state_q)
         S_REQ: begin
            if (redirect_i) begin
               pc_d    = target;
               state_d = imem_req_ready_i ? S_FLUSH : S_REQ;
            end else if (imem_req_ready_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_i) begin
               pc_d    = target;
               state_d = imem_rsp_valid_i ? S_REQ : S_FLUSH;
            end else if (imem_rsp_valid_i) begin
               instr_d  = imem_rsp_data_i;
               pc_out_d = pc_q;
               valid_d  = 1'b1;
               pc_d     = pc_q + PC_W'(4);
               state_d  = S_HOLD;
            end
         end
         S_FLUSH: begin
            if (redirect_i) pc_d = target;
            if (imem_rsp_valid_i) state_d = S_REQ;
         end
         S_HOLD: begin
            // A handshake coincident with a redirect still counts as consumed
            if (instr_ready_i) count_d = count_q + 32'd1;
            if (redirect_i) begin
               pc_d = target;
            end
            if (redirect_i || instr_ready_i) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   assign imem_req_valid_o = rstn && (state_q == S_REQ);
   assign imem_addr_o      = rstn ? pc_q : PC_W'(0);
   assign instr_valid_o    = valid_q;
   assign instr_o          = instr_q;
   assign pc_o             = pc_out_q;
   assign fetch_count_o    = count_q;

`ifndef SYNTHESIS
   // Only one request is ever outstanding, so no response may land in REQ or HOLD
   a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rstn)
      !(imem_rsp_valid_i && (state_q == S_REQ || state_q == S_HOLD)));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner-case sequences,
// and a randomized run checked against a sequential-fetch stream model.
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, req_valid, req_ready, rsp_valid, instr_valid, instr_ready, redirect;
   logic [31:0] addr, rsp_data, instr, pc, redirect_pc, fetch_count;

   logic        rstn1, req1_valid, rsp1_valid, instr1_valid;
   logic [31:0] addr1, rsp1_data, instr1, pc1, fetch_count1;
   logic        req1_ready = 1'b1, instr1_ready = 1'b1, redirect1 = 1'b0;
   logic [31:0] redirect1_pc = 32'h0;

   instr_fetch_unit dut (
      .clk(clk), .rstn(rstn),
      .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(addr),
      .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
      .instr_valid_o(instr_valid), .instr_ready_i(instr_ready), .instr_o(instr), .pc_o(pc),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc), .fetch_count_o(fetch_count));

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk(clk), .rstn(rstn1),
      .imem_req_valid_o(req1_valid), .imem_req_ready_i(req1_ready), .imem_addr_o(addr1),
      .imem_rsp_valid_i(rsp1_valid), .imem_rsp_data_i(rsp1_data),
      .instr_valid_o(instr1_valid), .instr_ready_i(instr1_ready), .instr_o(instr1), .pc_o(pc1),
      .redirect_i(redirect1), .redirect_pc_i(redirect1_pc), .fetch_count_o(fetch_count1));

   int checks = 0;
   int failures = 0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00A0_0113;
      return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model for dut: one response per accepted request, mem_lat cycles later
   int          mem_lat = 1;
   bit          mem_rand_lat = 1'b0;
   bit          m_pending = 1'b0;
   int          m_cnt = 0;
   logic [31:0] m_addr = 32'h0;
   initial begin
      rsp_valid = 1'b0;
      rsp_data  = 32'hDEAD_BEEF;
      forever begin
         @(posedge clk);
         if (!rstn) m_pending = 1'b0;
         else begin
            if (rsp_valid) m_pending = 1'b0;
            else if (m_pending) m_cnt--;
            if (req_valid && req_ready) begin
               checks++;
               if (m_pending) begin
                  failures++;
                  $display("FAIL one_outstanding actual=2 required=1 addr=%h", addr);
               end
               m_pending = 1'b1;
               m_addr    = addr;
               m_cnt     = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
            end
         end
         #1;
         rsp_valid = m_pending && (m_cnt == 1);
         rsp_data  = rsp_valid ? data_of(m_addr) : 32'hDEAD_BEEF;
      end
   end

   // Zero-wait memory for dut1
   initial begin
      logic        acc;
      logic [31:0] a;
      rsp1_valid = 1'b0;
      rsp1_data  = 32'h0;
      forever begin
         @(posedge clk);
         acc = rstn1 && req1_valid && req1_ready;
         a   = addr1;
         #1;
         rsp1_valid = acc;
         rsp1_data  = data_of(a);
      end
   end

   bit          mon1_en = 1'b0;
   logic [31:0] q1_pc[$];
   logic [31:0] q1_ins[$];
   initial forever begin
      @(negedge clk);
      if (mon1_en && instr1_valid && instr1_ready) begin
         q1_pc.push_back(pc1);
         q1_ins.push_back(instr1);
      end
   end

   // Stream model: decode sees consecutive words starting at the latest redirect target
   bit          mon_en = 1'b0;
   bit          exp_known = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] exp_pc = 32'h0, hs_cnt = 32'h0, cnt_base = 32'h0;
   logic [31:0] prev_pc = 32'h0, prev_instr = 32'h0;
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (prev_stall) begin
            chk("rnd_hold_valid", 32'(instr_valid), 32'd1);
            chk("rnd_hold_pc", pc, prev_pc);
            chk("rnd_hold_instr", instr, prev_instr);
         end
         chk("rnd_count", fetch_count, cnt_base + hs_cnt);
         if (req_valid) chk("rnd_addr_align", 32'(addr[1:0]), 32'd0);
         if (instr_valid && instr_ready) begin
            if (exp_known) chk("rnd_pc", pc, exp_pc);
            chk("rnd_instr", instr, data_of(pc));
            exp_pc = pc + 32'd4;
            hs_cnt = hs_cnt + 32'd1;
         end
         if (redirect) begin
            exp_pc    = redirect_pc & ~32'd3;
            exp_known = 1'b1;
         end
         prev_stall = instr_valid && !instr_ready && !redirect;
         prev_pc    = pc;
         prev_instr = instr;
      end
   end

   typedef struct {
      logic        rstn, rdy, ir;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_instr;
      logic        pc_chk;
      logic [31:0] e_pc, e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rd, input logic ir, input logic eq,
                               input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                               input logic pcc, input logic [31:0] ep, input logic [31:0] ec);
      vec_t v;
      v.rstn = r; v.rdy = rd; v.ir = ir; v.e_req = eq; v.e_addr = ea; v.e_v = ev;
      v.e_instr = ei; v.pc_chk = pcc; v.e_pc = ep; v.e_cnt = ec;
      return v;
   endfunction

   vec_t tbl[22];

   initial begin
      int          n;
      bit          stale;
      logic [31:0] c0;

      tbl[0]  = mk(0, 1, 1, 0, 32'h0, 0, NOP, 1, 32'h0, 0);
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = mk(1, 1, 1, 1, 32'h0, 0, NOP, 1, 32'h0, 0);
      tbl[4]  = mk(1, 1, 1, 0, 32'h0, 0, NOP, 1, 32'h0, 0);
      tbl[5]  = mk(1, 1, 1, 0, 32'h4, 1, data_of(32'h0), 1, 32'h0, 0);
      tbl[6]  = mk(1, 1, 1, 1, 32'h4, 0, NOP, 0, 32'h0, 1);
      tbl[7]  = mk(1, 1, 1, 0, 32'h4, 0, NOP, 0, 32'h0, 1);
      tbl[8]  = mk(1, 1, 1, 0, 32'h8, 1, data_of(32'h4), 1, 32'h4, 1);
      for (int i = 9; i < 13; i++) tbl[i] = mk(1, 0, 1, 1, 32'h8, 0, NOP, 0, 32'h0, 2);
      tbl[13] = mk(1, 1, 1, 1, 32'h8, 0, NOP, 0, 32'h0, 2);
      tbl[14] = mk(1, 1, 0, 0, 32'h8, 0, NOP, 0, 32'h0, 2);
      for (int i = 15; i < 20; i++) tbl[i] = mk(1, 1, 0, 0, 32'hC, 1, data_of(32'h8), 1, 32'h8, 2);
      tbl[20] = mk(1, 1, 1, 0, 32'hC, 1, data_of(32'h8), 1, 32'h8, 2);
      tbl[21] = mk(1, 0, 1, 1, 32'hC, 0, NOP, 0, 32'h0, 3);

      rstn = 1'b0; rstn1 = 1'b0;
      req_ready = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
      step();

      // Reset, basic fetch stream, request stall, decode stall
      for (int i = 0; i < 22; i++) begin
         rstn = tbl[i].rstn; req_ready = tbl[i].rdy; instr_ready = tbl[i].ir;
         @(negedge clk);
         chk($sformatf("v%0d_req_valid", i), 32'(req_valid), 32'(tbl[i].e_req));
         chk($sformatf("v%0d_addr", i), addr, tbl[i].e_addr);
         chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_v));
         chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
         if (tbl[i].pc_chk) chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
         chk($sformatf("v%0d_count", i), fetch_count, tbl[i].e_cnt);
         step();
      end

      // Redirect during WAIT with slow response: FLUSH, stale data dropped
      mem_lat = 3; req_ready = 1'b1; instr_ready = 1'b1;
      @(negedge clk);
      chk("a_req_valid", 32'(req_valid), 32'd1);
      chk("a_addr", addr, 32'hC);
      step();
      redirect = 1'b1; redirect_pc = 32'h103;
      @(negedge clk);
      chk("a_wait_no_req", 32'(req_valid), 32'd0);
      step();
      redirect = 1'b0;
      stale = 1'b0;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (instr_valid) stale = 1'b1;
         if (req_valid) break;
         step();
      end
      chk("a_no_stale", 32'(stale), 32'd0);
      chk("a_flush_cycles", 32'(n), 32'd2);
      chk("a_req_after_flush", 32'(req_valid), 32'd1);
      chk("a_addr_after_flush", addr, 32'h100);
      mem_lat = 1;
      step();
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (instr_valid) break;
         step();
      end
      chk("a_deliver_valid", 32'(instr_valid), 32'd1);
      chk("a_deliver_pc", pc, 32'h100);
      chk("a_deliver_instr", instr, data_of(32'h100));
      step();

      // Redirect coincident with rsp_valid: response dropped, straight back to REQ
      @(negedge clk);
      chk("b_req_valid", 32'(req_valid), 32'd1);
      chk("b_addr", addr, 32'h104);
      step();
      redirect = 1'b1; redirect_pc = 32'h103;
      @(negedge clk);
      chk("b_rsp_coincident", 32'(rsp_valid), 32'd1);
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("b_req_direct", 32'(req_valid), 32'd1);
      chk("b_addr_direct", addr, 32'h100);
      chk("b_no_instr", 32'(instr_valid), 32'd0);

      // Redirect coincident with decode handshake in HOLD
      instr_ready = 1'b0;
      step();
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (instr_valid) break;
         step();
      end
      chk("c_hold_valid", 32'(instr_valid), 32'd1);
      c0 = fetch_count;
      step();
      instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h2000;
      @(negedge clk);
      chk("c_still_hold", 32'(instr_valid), 32'd1);
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("c_count", fetch_count, c0 + 32'd1);
      chk("c_req_valid", 32'(req_valid), 32'd1);
      chk("c_addr", addr, 32'h2000);
      chk("c_valid_cleared", 32'(instr_valid), 32'd0);
      chk("c_instr_nop", instr, NOP);

      // Reset while WAITing on a slow response
      mem_lat = 3;
      step();
      rstn = 1'b0;
      @(negedge clk);
      chk("d_req_gated", 32'(req_valid), 32'd0);
      chk("d_addr_gated", addr, 32'h0);
      step();
      rstn = 1'b1; mem_lat = 1;
      @(negedge clk);
      chk("d_valid", 32'(instr_valid), 32'd0);
      chk("d_instr", instr, NOP);
      chk("d_pc", pc, 32'h0);
      chk("d_count", fetch_count, 32'h0);
      chk("d_req_valid", 32'(req_valid), 32'd1);
      chk("d_addr", addr, 32'h0);
      step();
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (instr_valid) break;
         step();
      end
      chk("d_refetch_valid", 32'(instr_valid), 32'd1);
      chk("d_refetch_pc", pc, 32'h0);
      chk("d_refetch_instr", instr, data_of(32'h0));
      step();

      // RESET_PC at the top of the address space wraps to 0
      rstn1 = 1'b1; mon1_en = 1'b1;
      @(negedge clk);
      chk("e_req_valid", 32'(req1_valid), 32'd1);
      chk("e_addr0", addr1, 32'hFFFF_FFFC);
      step();
      for (n = 0; n < 10; n++) begin
         @(negedge clk);
         if (req1_valid) break;
         step();
      end
      chk("e_req2_valid", 32'(req1_valid), 32'd1);
      chk("e_addr1", addr1, 32'h0);
      for (int i = 0; i < 6; i++) step();
      chk("e_delivered", 32'(q1_pc.size() >= 2), 32'd1);
      if (q1_pc.size() >= 2) begin
         chk("e_pc0", q1_pc[0], 32'hFFFF_FFFC);
         chk("e_ins0", q1_ins[0], data_of(32'hFFFF_FFFC));
         chk("e_pc1", q1_pc[1], 32'h0);
         chk("e_ins1", q1_ins[1], data_of(32'h0));
      end
      chk("e_count", fetch_count1, 32'(q1_pc.size()));
      mon1_en = 1'b0;

      // Randomized traffic against the stream model
      mem_rand_lat = 1'b1;
      cnt_base = fetch_count; hs_cnt = 32'h0; exp_known = 1'b0; prev_stall = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         req_ready   = ($urandom_range(0, 3) != 0);
         instr_ready = ($urandom_range(0, 2) != 0);
         redirect    = (i == 0) || ($urandom_range(0, 15) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : 32'($urandom);
         step();
      end
      redirect = 1'b0;
      @(negedge clk);
      mon_en = 1'b0;
      chk("rnd_progress", 32'(hs_cnt >= 32'd100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
